kbd_event_ctrl: RTL and testbench

- Sequences the PS/2 receive FIFO: pops one byte at a time through the `ready`/`nextdata_n` handshake.
- Decodes `E0`/`F0` prefixes and tracks the held key.
- Enforces a post-release hold-off window and suppresses typematic repeats.
- Delivers one key event per press to the command/text consumer over a valid/ready handshake. Sits between `ps2_keyboard` and the ASCII/command-check logic.

---
 rtl/kbd_event_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_kbd_event_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl
//
// Pops bytes from the PS/2 receive FIFO one at a time, decodes E0/F0 prefixes,
// tracks the currently held key, applies a post-release hold-off window and
// hands one key event per press to the consumer over a valid/ready handshake.
//
// Ports:
//   clk              system clock
//   clr              asynchronous active-high reset
//   fifo_data        head byte of the PS/2 FIFO
//   fifo_ready       FIFO non-empty
//   fifo_nextdata_n  active-low pop strobe (registered, one cycle low)
//   ev_valid         event available
//   ev_ready         consumer accepts the event
//   ev_code          make code of the event
//   ev_ext           event was E0-prefixed
//   ev_class         0 extended, 1 enter, 2 backspace, 3 ordinary character
//   held             a key is currently held down
//   drop_cnt         events lost to back-pressure (saturates at 255)
//
// Configuration macro: KBD_TYPEMATIC_EN
//   defined   - typematic repeats of the held key produce events
//   undefined - typematic repeats are silently discarded
module kbd_event_ctrl #(
    parameter int unsigned HOLDOFF = 2500000,
    parameter int unsigned CNT_W   = 22
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] fifo_data,
    input  logic       fifo_ready,
    output logic       fifo_nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic [1:0] ev_class,
    output logic       held,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {StIdle, StPop, StGap} state_e;

    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             pop_n_q, pop_n_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic             held_q, held_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             ev_valid_q, ev_valid_d;
    logic [7:0]       ev_code_q, ev_code_d;
    logic             ev_ext_q, ev_ext_d;
    logic [1:0]       ev_class_q, ev_class_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic gen;
    logic is_repeat;

    function automatic logic [1:0] class_of(input logic ext, input logic [7:0] code);
        if (ext) begin
            return 2'd0;
        end else if (code == 8'h5A) begin
            return 2'd1;
        end else if (code == 8'h66) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

    assign is_repeat = held_q && (byte_q == held_code_q) && (ext_pend_q == held_ext_q);

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        pop_n_d     = pop_n_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        held_d      = held_q;
        held_code_d = held_code_q;
        held_ext_d  = held_ext_q;
        ev_valid_d  = ev_valid_q;
        ev_code_d   = ev_code_q;
        ev_ext_d    = ev_ext_q;
        ev_class_d  = ev_class_q;
        drop_cnt_d  = drop_cnt_q;
        gen         = 1'b0;
        hold_cnt_d  = (hold_cnt_q != '0) ? hold_cnt_q - CNT_W'(1) : hold_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (fifo_ready) begin
                    byte_d  = fifo_data;
                    pop_n_d = 1'b0;
                    state_d = StPop;
                end
            end
            StPop: begin
                pop_n_d = 1'b1;
                state_d = StGap;
                if (byte_q == 8'hE0) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_pend_d = 1'b1;
                end else if (brk_pend_q) begin
                    // Only the release of the key we consider held starts a hold-off.
                    if (is_repeat) begin
                        held_d     = 1'b0;
                        hold_cnt_d = CNT_W'(HOLDOFF);
                    end
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end else begin
                    if (hold_cnt_q == '0) begin
                        if (is_repeat) begin
`ifdef KBD_TYPEMATIC_EN
                            gen = 1'b1;
`else
                            gen = 1'b0;
`endif
                        end else begin
                            gen         = 1'b1;
                            held_d      = 1'b1;
                            held_code_d = byte_q;
                            held_ext_d  = ext_pend_q;
                        end
                    end
                    ext_pend_d = 1'b0;
                end
            end
            StGap: begin
                // Lets fifo_ready settle after the pop before it is sampled again.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Depth-1 event register: a new event while the old one is stuck is dropped.
        if (gen) begin
            if (ev_valid_q && !ev_ready) begin
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end else begin
                ev_valid_d = 1'b1;
                ev_code_d  = byte_q;
                ev_ext_d   = ext_pend_q;
                ev_class_d = class_of(ext_pend_q, byte_q);
            end
        end else if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= StIdle;
            byte_q      <= 8'h00;
            pop_n_q     <= 1'b1;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            held_q      <= 1'b0;
            held_code_q <= 8'h00;
            held_ext_q  <= 1'b0;
            hold_cnt_q  <= '0;
            ev_valid_q  <= 1'b0;
            ev_code_q   <= 8'h00;
            ev_ext_q    <= 1'b0;
            ev_class_q  <= 2'd0;
            drop_cnt_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            pop_n_q     <= pop_n_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            held_q      <= held_d;
            held_code_q <= held_code_d;
            held_ext_q  <= held_ext_d;
            hold_cnt_q  <= hold_cnt_d;
            ev_valid_q  <= ev_valid_d;
            ev_code_q   <= ev_code_d;
            ev_ext_q    <= ev_ext_d;
            ev_class_q  <= ev_class_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign fifo_nextdata_n = pop_n_q;
    assign ev_valid        = ev_valid_q;
    assign ev_code         = ev_code_q;
    assign ev_ext          = ev_ext_q;
    assign ev_class        = ev_class_q;
    assign held            = held_q;
    assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Testbench for kbd_event_ctrl: byte-level behavioural model with cycle-time
// hold-off, compared against the DUT every cycle, plus directed literal checks.
module tb_kbd_event_ctrl;

    localparam int unsigned HOLDOFF = 15;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] fifo_data;
    logic       fifo_ready;
    logic       fifo_nextdata_n;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic [1:0] ev_class;
    logic       held;
    logic [7:0] drop_cnt;

    kbd_event_ctrl #(
        .HOLDOFF(HOLDOFF),
        .CNT_W  (4)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .fifo_data      (fifo_data),
        .fifo_ready     (fifo_ready),
        .fifo_nextdata_n(fifo_nextdata_n),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_code        (ev_code),
        .ev_ext         (ev_ext),
        .ev_class       (ev_class),
        .held           (held),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // FIFO model, popped bytes and consumed events
    logic [7:0]  fq[$];
    logic [10:0] acc_q[$];   // {ext, class, code}
    bit          dec_pend = 1'b0;
    logic [7:0]  dec_byte = 8'h00;
    int          pops = 0;
    int          last_pop = -1;
    bit          held_seen = 1'b0;

    // Behavioural model state
    int         cyc = 0;
    bit         m_extp, m_brkp, m_held, m_hext;
    logic [7:0] m_hcode;
    bit         rel_seen;
    int         rel_cyc;
    int         rel_cnt = 0;
    bit         m_valid, m_ext;
    logic [7:0] m_code;
    logic [1:0] m_class;
    int         m_drop;

    always @(negedge clk) begin
        if (ev_valid && ev_ready) acc_q.push_back({ev_ext, ev_class, ev_code});
        if (held) held_seen = 1'b1;
        if (!clr && fifo_nextdata_n == 1'b0) begin
            chk("pop_nonempty", fq.size() != 0, 1);
            if (fq.size() != 0) begin
                dec_byte = fq.pop_front();
                dec_pend = 1'b1;
            end
            pops++;
            if (last_pop >= 0) chk("pop_gap_ge3", (cyc - last_pop) >= 3, 1);
            last_pop = cyc;
        end
        fifo_ready = (fq.size() != 0);
        fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
    end

    always @(posedge clk) begin : model
        bit         gen;
        bit         g_ext;
        logic [7:0] g_code;
        cyc++;
        gen = 1'b0;
        g_ext = 1'b0;
        g_code = 8'h00;
        if (clr) begin
            m_extp = 0; m_brkp = 0; m_held = 0; m_hext = 0; m_hcode = 8'h00;
            rel_seen = 0; m_valid = 0; m_ext = 0; m_code = 8'h00; m_class = 2'd0;
            m_drop = 0; dec_pend = 1'b0; last_pop = -1;
        end else begin
            if (dec_pend) begin
                dec_pend = 1'b0;
                if (dec_byte == 8'hE0) begin
                    m_extp = 1;
                end else if (dec_byte == 8'hF0) begin
                    m_brkp = 1;
                end else if (m_brkp) begin
                    if (m_held && dec_byte == m_hcode && m_extp == m_hext) begin
                        m_held = 0;
                        rel_seen = 1;
                        rel_cyc = cyc;
                        rel_cnt++;
                    end
                    m_extp = 0;
                    m_brkp = 0;
                end else begin
                    g_code = dec_byte;
                    g_ext = m_extp;
                    if (rel_seen && (cyc - rel_cyc) <= int'(HOLDOFF)) begin
                        gen = 0;
                    end else if (m_held && dec_byte == m_hcode && m_extp == m_hext) begin
`ifdef KBD_TYPEMATIC_EN
                        gen = 1;
`endif
                    end else begin
                        gen = 1;
                        m_held = 1;
                        m_hcode = dec_byte;
                        m_hext = m_extp;
                    end
                    m_extp = 0;
                end
            end
            if (gen) begin
                if (m_valid && !ev_ready) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_valid = 1;
                    m_code = g_code;
                    m_ext = g_ext;
                    m_class = g_ext ? 2'd0 : (g_code == 8'h5A) ? 2'd1 :
                              (g_code == 8'h66) ? 2'd2 : 2'd3;
                end
            end else if (m_valid && ev_ready) begin
                m_valid = 0;
            end
        end
        #1;
        chk("outputs_vs_model", {11'd0, ev_valid, ev_code, ev_ext, ev_class, held, drop_cnt},
            {11'd0, m_valid, m_code, m_ext, m_class, m_held, m_drop[7:0]});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (fq.size() != 0 && t < 200) begin
            step(1);
            t++;
        end
        chk("fifo_drain_in_time", fq.size() == 0, 1);
        step(5);
    endtask

    task automatic wait_rel();
        int old = rel_cnt;
        int t = 0;
        while (rel_cnt == old && t < 100) begin
            step(1);
            t++;
        end
        chk("release_decoded", rel_cnt != old, 1);
    endtask

    // Push b so that it is decoded exactly k cycles after the last release decode.
    task automatic decode_at(input logic [7:0] b, input int k);
        int t = 0;
        while (cyc < rel_cyc + k - 2 && t < 100) begin
            step(1);
            t++;
        end
        chk("decode_slot", cyc, rel_cyc + k - 2);
        fq.push_back(b);
    endtask

    task automatic chk_reset(input string name);
        chk(name, {fifo_nextdata_n, ev_valid, ev_code, ev_ext, ev_class, held, drop_cnt},
            {1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00});
    endtask

    initial begin
        int base;
        int pbase;
        int exp_n;
        clr = 1'b1;
        ev_ready = 1'b1;
        step(3);
        chk_reset("reset_values");
        clr = 1'b0;
        step(2);

        // Single key press and release
        base = acc_q.size();
        pbase = pops;
        held_seen = 1'b0;
        fq.push_back(8'h1C); fq.push_back(8'hF0); fq.push_back(8'h1C);
        wait_idle();
        chk("t1_event_count", acc_q.size() - base, 1);
        chk("t1_event", acc_q[base], {1'b0, 2'd3, 8'h1C});
        chk("t1_held_was_1", held_seen, 1);
        chk("t1_held_end", held, 0);
        chk("t1_pop_count", pops - pbase, 3);
        step(20);

        // Enter, release, hold-off discard then accept
        base = acc_q.size();
        fq.push_back(8'h5A);
        wait_idle();
        fq.push_back(8'hF0); fq.push_back(8'h5A);
        wait_rel();
        decode_at(8'h66, 5);
        decode_at(8'h66, 20);
        wait_idle();
        chk("t2_event_count", acc_q.size() - base, 2);
        chk("t2_enter", acc_q[base], {1'b0, 2'd1, 8'h5A});
        chk("t2_bksp", acc_q[base+1], {1'b0, 2'd2, 8'h66});

        // Hold-off boundary: counter reading 1 discards, reading 0 accepts
        base = acc_q.size();
        fq.push_back(8'hF0); fq.push_back(8'h66);
        wait_rel();
        decode_at(8'h66, 15);
        wait_idle();
        chk("t2b_k15_discard", acc_q.size() - base, 0);
        chk("t2b_k15_not_held", held, 0);
        step(20);
        fq.push_back(8'h66);
        wait_idle();
        fq.push_back(8'hF0); fq.push_back(8'h66);
        wait_rel();
        decode_at(8'h66, 16);
        wait_idle();
        chk("t2b_k16_accept", acc_q.size() - base, 2);
        chk("t2b_k16_held", held, 1);
        fq.push_back(8'hF0); fq.push_back(8'h66);
        wait_idle();
        step(20);

        // Extended key
        base = acc_q.size();
        fq.push_back(8'hE0); fq.push_back(8'h75);
        wait_idle();
        fq.push_back(8'hE0); fq.push_back(8'hF0); fq.push_back(8'h75);
        wait_idle();
        chk("t3_event_count", acc_q.size() - base, 1);
        chk("t3_event", acc_q[base], {1'b1, 2'd0, 8'h75});
        chk("t3_held_end", held, 0);
        step(20);

        // Typematic repeats
        base = acc_q.size();
        fq.push_back(8'h1C); fq.push_back(8'h1C); fq.push_back(8'h1C);
        wait_idle();
        fq.push_back(8'hF0); fq.push_back(8'h1C);
        wait_idle();
`ifdef KBD_TYPEMATIC_EN
        exp_n = 3;
`else
        exp_n = 1;
`endif
        chk("t4_event_count", acc_q.size() - base, exp_n);
        chk("t4_last_code", acc_q[acc_q.size()-1], {1'b0, 2'd3, 8'h1C});
        chk("t4_drop_cnt", drop_cnt, 0);
        step(20);

        // Back-pressure drop
        ev_ready = 1'b0;
        fq.push_back(8'h1C);
        wait_idle();
        fq.push_back(8'hF0); fq.push_back(8'h1C);
        wait_idle();
        step(20);
        fq.push_back(8'h32);
        wait_idle();
        chk("t5_code_kept", ev_code, 8'h1C);
        chk("t5_valid", ev_valid, 1);
        chk("t5_drop_cnt", drop_cnt, 1);
        ev_ready = 1'b1;
        step(1);
        chk("t5_valid_cleared", ev_valid, 0);

        // Reset between prefix and code
        fq.push_back(8'hE0);
        wait_idle();
        clr = 1'b1;
        #1;
        chk_reset("t6_reset_async");
        step(1);
        chk_reset("t6_reset_held");
        clr = 1'b0;
        step(1);
        fq.push_back(8'h75);
        wait_idle();
        chk("t6_event", acc_q[acc_q.size()-1], {1'b0, 2'd3, 8'h75});
        chk("t6_drop_cnt", drop_cnt, 0);

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
